// File: rtl/vga_update_sched.sv
// Double-buffered display-register scheduler: two write ports arbitrate into shadow
// registers, which are copied to the active outputs only during vertical blanking.
module vga_update_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        h_req,
    input  logic [2:0]  h_addr,
    input  logic [31:0] h_data,
    output logic        h_gnt,
    input  logic        a_req,
    input  logic [2:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_gnt,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [7:0]  pos_h,
    output logic [7:0]  pos_v,
    output logic [23:0] bg_rgb,
    output logic [15:0] frame_cnt,
    output logic        irq,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COMMIT
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_prio_a;
    logic [7:0]  r_sh_pos_v;
    logic [7:0]  r_sh_pos_h;
    logic [23:0] r_sh_bg;
    logic        r_irq_en;
    logic [7:0]  r_pos_v;
    logic [7:0]  r_pos_h;
    logic [23:0] r_bg;
    logic        r_irq;
    logic [15:0] r_frame;

    logic        w_wr;
    logic [2:0]  w_addr;
    logic [31:0] w_data;
    logic        w_vblank;
    logic        w_commit_req;
    logic        w_unused_data;

    // r_prio_a marks the accelerator as winner of the next simultaneous request
    always_comb begin
        h_gnt = h_req && (!a_req || !r_prio_a);
        a_gnt = a_req && !h_gnt;
    end

    always_comb begin
        w_wr   = h_gnt || a_gnt;
        w_addr = h_gnt ? h_addr : a_addr;
        w_data = h_gnt ? h_data : a_data;
    end

    assign w_unused_data = ^w_data[31:24];
    assign w_vblank      = (vcount == 10'd480) && (hcount == 11'd0);
    assign w_commit_req  = w_wr && (w_addr == 3'd3) && w_data[0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_commit_req) w_next = S_ARMED;
            S_ARMED:  if (w_vblank) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio_a   <= 1'b0;
            r_sh_pos_v <= '0;
            r_sh_pos_h <= '0;
            r_sh_bg    <= 24'h000080;
            r_irq_en   <= 1'b0;
            r_pos_v    <= '0;
            r_pos_h    <= '0;
            r_bg       <= 24'h000080;
            r_irq      <= 1'b0;
            r_frame    <= '0;
        end else begin
            if (h_gnt)      r_prio_a <= 1'b1;
            else if (a_gnt) r_prio_a <= 1'b0;

            // Copy uses pre-edge shadows, so a write landing on this edge waits for the next commit
            if (r_state == S_COMMIT) begin
                r_pos_v <= r_sh_pos_v;
                r_pos_h <= r_sh_pos_h;
                r_bg    <= r_sh_bg;
            end

            if (w_wr) begin
                case (w_addr)
                    3'd0:    r_sh_pos_v <= w_data[7:0];
                    3'd1:    r_sh_pos_h <= w_data[7:0];
                    3'd2:    r_sh_bg    <= w_data[23:0];
                    3'd3:    r_irq_en   <= w_data[1];
                    default: ;
                endcase
            end

            if ((r_state == S_COMMIT) && r_irq_en) r_irq <= 1'b1;
            else if (w_wr && (w_addr == 3'd4))     r_irq <= 1'b0;

            if (w_vblank) r_frame <= r_frame + 16'd1;
        end
    end

    assign pos_v     = r_pos_v;
    assign pos_h     = r_pos_h;
    assign bg_rgb    = r_bg;
    assign frame_cnt = r_frame;
    assign irq       = r_irq;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_vga_update_sched.sv
// Scoreboard bench for vga_update_sched: per-cycle expectations from a reference model
// are queued by the stimulus process and checked by an independent monitor.
module tb_vga_update_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        h_req, a_req;
    logic [2:0]  h_addr, a_addr;
    logic [31:0] h_data, a_data;
    logic        h_gnt, a_gnt;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [7:0]  pos_h, pos_v;
    logic [23:0] bg_rgb;
    logic [15:0] frame_cnt;
    logic        irq, busy;

    always #5 clk = ~clk;

    vga_update_sched dut (
        .clk(clk), .reset(reset),
        .h_req(h_req), .h_addr(h_addr), .h_data(h_data), .h_gnt(h_gnt),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .hcount(hcount), .vcount(vcount),
        .pos_h(pos_h), .pos_v(pos_v), .bg_rgb(bg_rgb), .frame_cnt(frame_cnt),
        .irq(irq), .busy(busy)
    );

    typedef struct {
        logic        gh, ga;
        logic [7:0]  ph, pv;
        logic [23:0] bg;
        logic [15:0] fc;
        logic        irq, busy;
    } exp_t;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    exp_t q[$];
    wr_t  hq[$], aq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: phase 0 = waiting, 1 = commit pending, 2 = committing this cycle
    bit          m_turn_a;
    int          m_phase;
    logic [7:0]  s_h, s_v, o_h, o_v;
    logic [23:0] s_bg, o_bg;
    bit          m_ien, m_irq;
    logic [15:0] m_fc;

    task automatic model_reset();
        m_turn_a = 1'b0; m_phase = 0;
        s_h = 8'h00; s_v = 8'h00; o_h = 8'h00; o_v = 8'h00;
        s_bg = 24'h000080; o_bg = 24'h000080;
        m_ien = 1'b0; m_irq = 1'b0; m_fc = 16'h0000;
        hq.delete(); aq.delete();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input int hc, input int vc);
        exp_t        e;
        bit          gh, ga, wr, vb, commit_now;
        logic [2:0]  wa;
        logic [31:0] wd;
        int          nphase;
        @(negedge clk);
        hcount = hc[10:0];
        vcount = vc[9:0];
        h_req  = (hq.size() > 0);
        a_req  = (aq.size() > 0);
        h_addr = h_req ? hq[0].addr : 3'd0;
        h_data = h_req ? hq[0].data : 32'd0;
        a_addr = a_req ? aq[0].addr : 3'd0;
        a_data = a_req ? aq[0].data : 32'd0;

        gh = h_req && (!a_req || !m_turn_a);
        ga = a_req && !gh;
        wr = gh || ga;
        wa = gh ? h_addr : a_addr;
        wd = gh ? h_data : a_data;
        vb = (vc == 480) && (hc == 0);
        commit_now = (m_phase == 2);

        if (commit_now) begin
            o_h = s_h; o_v = s_v; o_bg = s_bg;
        end
        if (commit_now && m_ien)   m_irq = 1'b1;
        else if (wr && wa == 3'd4) m_irq = 1'b0;

        nphase = m_phase;
        if (m_phase == 2)                           nphase = 0;
        else if (m_phase == 1 && vb)                nphase = 2;
        else if (m_phase == 0 && wr && wa == 3'd3 && wd[0]) nphase = 1;
        m_phase = nphase;

        if (wr && wa == 3'd0) s_v  = wd[7:0];
        if (wr && wa == 3'd1) s_h  = wd[7:0];
        if (wr && wa == 3'd2) s_bg = wd[23:0];
        if (wr && wa == 3'd3) m_ien = wd[1];
        if (vb) m_fc = m_fc + 16'd1;
        if (gh) begin m_turn_a = 1'b1; void'(hq.pop_front()); end
        if (ga) begin m_turn_a = 1'b0; void'(aq.pop_front()); end

        e.gh = gh; e.ga = ga; e.ph = o_h; e.pv = o_v; e.bg = o_bg;
        e.fc = m_fc; e.irq = m_irq; e.busy = (m_phase != 0);
        if (mon_en) q.push_back(e);
    endtask

    task automatic run(input int n, input int hc, input int vc);
        for (int i = 0; i < n; i++) cycle(hc, vc);
    endtask

    task automatic hw(input logic [2:0] ad, input logic [31:0] d);
        wr_t w; w.addr = ad; w.data = d; hq.push_back(w);
    endtask

    task automatic aw(input logic [2:0] ad, input logic [31:0] d);
        wr_t w; w.addr = ad; w.data = d; aq.push_back(w);
    endtask

    // Monitor: grants sampled mid-cycle, registered outputs just after the edge
    initial begin
        exp_t e;
        logic gs_h, gs_a;
        forever begin
            @(negedge clk); #2;
            gs_h = h_gnt; gs_a = a_gnt;
            @(posedge clk); #1;
            if (mon_en) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("h_gnt", gs_h, e.gh);
                    chk("a_gnt", gs_a, e.ga);
                    chk("pos_h", pos_h, e.ph);
                    chk("pos_v", pos_v, e.pv);
                    chk("bg_rgb", bg_rgb, e.bg);
                    chk("frame_cnt", frame_cnt, e.fc);
                    chk("irq", irq, e.irq);
                    chk("busy", busy, e.busy);
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_pos_h"}, pos_h, 32'h0);
        chk({tag, "_pos_v"}, pos_v, 32'h0);
        chk({tag, "_bg_rgb"}, bg_rgb, 32'h000080);
        chk({tag, "_frame_cnt"}, frame_cnt, 32'h0);
        chk({tag, "_irq"}, irq, 32'h0);
        chk({tag, "_busy"}, busy, 32'h0);
    endtask

    initial begin
        int hc, vc, r;
        reset = 1'b1;
        h_req = 1'b0; a_req = 1'b0; h_addr = '0; a_addr = '0; h_data = '0; a_data = '0;
        hcount = '0; vcount = 10'd100;
        model_reset();
        #23;
        check_reset_values("reset");
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("idle_h_gnt", h_gnt, 32'h0);
        chk("idle_a_gnt", a_gnt, 32'h0);
        mon_en = 1'b1;

        // Both ports held for four writes: grants alternate starting with host
        hw(3'd0, 32'h11); hw(3'd1, 32'h12);
        aw(3'd2, 32'h00123456); aw(3'd0, 32'h13);
        run(6, 5, 100);

        // Deferred position update
        hw(3'd1, 32'h14); hw(3'd3, 32'h1);
        run(6, 5, 100);
        run(1, 0, 480);
        run(4, 7, 480);

        // irq enable + commit, then set/clear collision, then plain clear
        hw(3'd3, 32'h3);
        run(3, 9, 200);
        run(1, 0, 480);
        run(4, 9, 200);
        hw(3'd3, 32'h3);
        run(3, 9, 200);
        run(1, 0, 480);
        hw(3'd4, 32'h0);
        run(4, 9, 200);
        hw(3'd4, 32'h0);
        run(3, 9, 200);

        // Shadow write in the commit cycle is deferred to the next commit
        hw(3'd0, 32'h40); hw(3'd3, 32'h1);
        run(4, 3, 10);
        run(1, 0, 480);
        aw(3'd0, 32'h22);
        run(4, 3, 10);
        hw(3'd3, 32'h1);
        run(3, 3, 10);
        run(1, 0, 480);
        run(4, 3, 10);

        // Randomised traffic with frequent and near-miss vblank timing
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && hq.size() < 3) hw(3'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 3) == 0 && aq.size() < 3) aw(3'($urandom_range(0, 7)), $urandom);
            r = $urandom_range(0, 19);
            if (r == 0)      begin hc = 0; vc = 480; end
            else if (r == 1) begin hc = 1; vc = 480; end
            else if (r == 2) begin hc = 0; vc = 479; end
            else begin hc = $urandom_range(0, 1599); vc = $urandom_range(0, 524); end
            cycle(hc, vc);
        end
        while (hq.size() > 0 || aq.size() > 0) cycle(5, 100);

        // Reset while a commit is pending
        hw(3'd1, 32'h55); hw(3'd2, 32'h00ABCDEF); hw(3'd3, 32'h3);
        run(5, 5, 100);
        chk("armed_before_reset", busy, 32'h1);
        @(posedge clk); #3;
        mon_en = 1'b0;
        reset = 1'b1;
        h_req = 1'b0; a_req = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge clk); #3;
        reset = 1'b0;
        mon_en = 1'b1;
        run(1, 0, 480);
        run(3, 5, 100);

        // frame counter wrap over 65536 vblank events
        for (int i = 0; i < 65535; i++) cycle(0, 480);
        run(1, 5, 100);
        chk("frame_wrap", frame_cnt, 32'h0);

        @(posedge clk); #3;
        mon_en = 1'b0;
        @(posedge clk); #3;
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
